// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitude on the way in, result negation/sign restore on the way out.
// Zero latency; no flow control of its own.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] a_abs,
  output logic [WIDTH-1:0] b_abs,
  output logic             a_neg,
  output logic             b_neg,
  input  logic [1:0]       res_op,
  input  logic             res_a_neg,
  input  logic             res_b_neg,
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic             in_signed;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = in_signed & src_a[WIDTH-1];
  assign b_neg     = in_signed & src_b[WIDTH-1];
  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  assign a_abs     = a_neg ? -src_a : src_a;
  assign b_abs     = b_neg ? -src_b : src_b;

  assign prod     = {raw_hi, raw_lo};
  assign prod_neg = -prod;

  always_comb begin
    fix_hi = raw_hi;
    fix_lo = raw_lo;
    case (res_op)
      OP_MULT: begin
        if (res_a_neg ^ res_b_neg) begin
          fix_hi = prod_neg[2*WIDTH-1:WIDTH];
          fix_lo = prod_neg[WIDTH-1:0];
        end
      end
      OP_DIV: begin
        // raw_lo holds the quotient, raw_hi the remainder (remainder follows the dividend).
        if (res_a_neg ^ res_b_neg) fix_lo = -raw_lo;
        if (res_a_neg) fix_hi = -raw_hi;
      end
      default: begin
        fix_hi = raw_hi;
        fix_lo = raw_lo;
      end
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, one bit per cycle; done WIDTH+1 cycles after start.
// busy tells the hazard unit to stall; abort cancels an in-flight op without touching HI/LO.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state;
  logic [1:0]       op_q;
  logic             a_neg_q;
  logic             b_neg_q;
  logic             b_zero_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  logic             is_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .a_abs     (a_abs),
    .b_abs     (b_abs),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .res_op    (op_q),
    .res_a_neg (a_neg_q),
    .res_b_neg (b_neg_q),
    .raw_hi    (acc_hi),
    .raw_lo    (acc_lo),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  assign is_div = op_q[1];

  // Both ops share {acc_hi, acc_lo}: acc_lo starts as |a| and is shifted out
  // as multiplier bits or shifted in as quotient bits.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        nxt_hi = div_diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      b_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !abort) begin
            op_q     <= op;
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            b_zero_q <= (src_b == '0);
            b_q      <= b_abs;
            acc_hi   <= '0;
            acc_lo   <= a_abs;
            cnt      <= CNT_W'(WIDTH);
            busy_q   <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= ST_IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              dbz_q  <= is_div & b_zero_q;
              state  <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          // A zero divisor leaves the architectural HI/LO untouched.
          if (!abort && !(is_div && b_zero_q)) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
          state <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  // An abort landing in FIN cancels the write, so it must also retract the pulse.
  assign done        = done_q & ~abort;
  assign div_by_zero = dbz_q & ~abort;

endmodule
